// File: rtl/alu16_seq_pkg.sv
// alu16_seq_pkg: shared constants and types for the 16-bit ALU sequencer.
//   - 8-bit ALU opcode constants (subset used by the sequencer plus neighbours)
//   - F register bit indices {Z,N,H,C}
//   - sequencer operation encodings
//   - sequencer FSM state encodings
package alu16_seq_pkg;

    // 8-bit ALU opcodes
    localparam logic [4:0] OP_ADD = 5'b00000;
    localparam logic [4:0] OP_ADC = 5'b00001;
    localparam logic [4:0] OP_SUB = 5'b00010;
    localparam logic [4:0] OP_SBC = 5'b00011;
    localparam logic [4:0] OP_AND = 5'b00100;
    localparam logic [4:0] OP_XOR = 5'b00101;
    localparam logic [4:0] OP_OR  = 5'b00110;
    localparam logic [4:0] OP_CP  = 5'b00111;

    // Flag bit positions within the 4-bit F nibble
    localparam int unsigned F_Z = 3;
    localparam int unsigned F_N = 2;
    localparam int unsigned F_H = 1;
    localparam int unsigned F_C = 0;

    // Sequencer operations
    typedef enum logic [1:0] {
        SEQ_ADD16 = 2'd0,
        SEQ_ADDSP = 2'd1,
        SEQ_INC16 = 2'd2,
        SEQ_DEC16 = 2'd3
    } seq_op_e;

    // Sequencer FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2
    } seq_state_e;

endpackage

// File: rtl/alu16_seq_if.sv
// alu16_seq_if: request/response bundle between the CPU control unit and the
// 16-bit ALU sequencer.
//   start     request (sampled only while idle)
//   op        sequencer operation (0=ADD16, 1=ADDSP, 2=INC16, 3=DEC16)
//   opnd_a    first operand (HL, SP or rr)
//   opnd_b    second operand (rr for ADD16, e8 in [7:0] for ADDSP)
//   flags_in  current F register {Z,N,H,C}
//   busy      operation in progress
//   done      one-cycle completion pulse
//   result    registered 16-bit result
//   flags_out registered new flags {Z,N,H,C}
// Modports: master = control unit side, slave = sequencer side.
interface alu16_seq_if;

    logic        start;
    logic [1:0]  op;
    logic [15:0] opnd_a;
    logic [15:0] opnd_b;
    logic [3:0]  flags_in;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic [3:0]  flags_out;

    modport master (
        output start, op, opnd_a, opnd_b, flags_in,
        input  busy, done, result, flags_out
    );

    modport slave (
        input  start, op, opnd_a, opnd_b, flags_in,
        output busy, done, result, flags_out
    );

endinterface

// File: rtl/alu16_seq.sv
// alu16_seq: runs 16-bit ADD HL,rr / ADD SP,e8 / INC rr / DEC rr through the
// shared 8-bit ALU as two passes (low byte, then high byte). The low pass's
// carry/borrow is registered and fed into the high pass.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   bus             request/response bundle (alu16_seq_if.slave)
//   alu_a, alu_b    operands presented to the 8-bit ALU (ALU computes b op a)
//   alu_op          ALU opcode
//   alu_flags_in    flags presented to the ALU (only C is ever non-zero)
//   alu_result      ALU result, combinational from the alu_* drive
//   alu_flags_out   ALU flags, combinational; C is carry for add, borrow for sub
module alu16_seq
    import alu16_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    alu16_seq_if.slave  bus,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [4:0]  alu_op,
    output logic [3:0]  alu_flags_in,
    input  logic [7:0]  alu_result,
    input  logic [3:0]  alu_flags_out
);

    seq_state_e  state, state_nxt;

    seq_op_e     lat_op;
    logic [15:0] lat_a;
    logic [15:0] lat_b;
    logic [3:0]  lat_flags;

    logic [7:0]  res_lo;
    logic        f_lo_h;
    logic        f_lo_c;

    logic        done_r;
    logic [15:0] result_r;
    logic [3:0]  flags_r;
    logic [3:0]  flags_hi;

    // Z and N from the ALU never contribute to the 16-bit flags.
    logic        alu_zn_unused;
    assign alu_zn_unused = alu_flags_out[F_Z] ^ alu_flags_out[F_N];

    assign bus.busy      = (state != ST_IDLE);
    assign bus.done      = done_r;
    assign bus.result    = result_r;
    assign bus.flags_out = flags_r;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and ALU drive
    always_comb begin
        state_nxt    = state;
        alu_a        = '0;
        alu_b        = '0;
        alu_op       = OP_ADD;
        alu_flags_in = '0;

        unique case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    state_nxt = ST_LO;
                end
            end

            ST_LO: begin
                state_nxt = ST_HI;
                alu_b     = lat_a[7:0];
                unique case (lat_op)
                    SEQ_ADD16: alu_a = lat_b[7:0];
                    SEQ_ADDSP: alu_a = lat_b[7:0];
                    SEQ_INC16: alu_a = 8'h01;
                    SEQ_DEC16: begin
                        alu_a  = 8'h01;
                        alu_op = OP_SUB;
                    end
                    default: ;
                endcase
            end

            ST_HI: begin
                state_nxt          = ST_IDLE;
                alu_b              = lat_a[15:8];
                alu_op             = OP_ADC;
                alu_flags_in[F_C]  = f_lo_c;
                unique case (lat_op)
                    SEQ_ADD16: alu_a = lat_b[15:8];
                    // Sign extension of e8 folded into the high-pass operand
                    SEQ_ADDSP: alu_a = {8{lat_b[7]}};
                    SEQ_INC16: alu_a = 8'h00;
                    SEQ_DEC16: begin
                        alu_a  = 8'h00;
                        alu_op = OP_SBC;
                    end
                    default: ;
                endcase
            end

            default: state_nxt = ST_IDLE;
        endcase
    end

    // Flags written at completion
    always_comb begin
        flags_hi = lat_flags;
        unique case (lat_op)
            SEQ_ADD16: begin
                flags_hi[F_N] = 1'b0;
                flags_hi[F_H] = alu_flags_out[F_H];
                flags_hi[F_C] = alu_flags_out[F_C];
            end
            // ADD SP,e8 takes H/C from the unsigned low-byte add only
            SEQ_ADDSP: flags_hi = {1'b0, 1'b0, f_lo_h, f_lo_c};
            default:   flags_hi = lat_flags;
        endcase
    end

    // Operand latch, low-pass capture and completion registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_op    <= SEQ_ADD16;
            lat_a     <= '0;
            lat_b     <= '0;
            lat_flags <= '0;
            res_lo    <= '0;
            f_lo_h    <= 1'b0;
            f_lo_c    <= 1'b0;
            done_r    <= 1'b0;
            result_r  <= '0;
            flags_r   <= '0;
        end else begin
            done_r <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        lat_op    <= seq_op_e'(bus.op);
                        lat_a     <= bus.opnd_a;
                        lat_b     <= bus.opnd_b;
                        lat_flags <= bus.flags_in;
                    end
                end
                ST_LO: begin
                    res_lo <= alu_result;
                    f_lo_h <= alu_flags_out[F_H];
                    f_lo_c <= alu_flags_out[F_C];
                end
                ST_HI: begin
                    result_r <= {alu_result, res_lo};
                    flags_r  <= flags_hi;
                    done_r   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
